// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver fed by an external 3-bit scan index.
// Display data is double-buffered and only committed on a 7->0 frame wrap; anodes are blanked after every digit change.
module seg7_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 4,
  parameter bit          LZ_SUPPRESS  = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [0:2]  select,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_mask,
  input  logic        load,
  output logic        loaded,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [3:0] BLANK_INIT   = 4'(BLANK_CYCLES);
  localparam logic [3:0] BLANK_RELOAD = (BLANK_CYCLES == 0) ? 4'd0 : 4'(BLANK_CYCLES - 1);

  // select is declared [0:2]; select[0] is the MSB of the index.
  logic [2:0] sel_in;
  assign sel_in = {select[0], select[1], select[2]};

  logic [0:0]  state;
  logic [0:0]  state_d;
  logic [3:0]  blank_cnt;
  logic [3:0]  blank_cnt_d;
  logic [2:0]  sel_q;
  logic [2:0]  sel_d;

  logic [31:0] stg_digits;
  logic [7:0]  stg_dp;
  logic [7:0]  stg_mask;
  logic        pending;

  logic [31:0] shd_digits;
  logic [7:0]  shd_dp;
  logic [7:0]  shd_mask;
  logic [31:0] shd_digits_d;
  logic [7:0]  shd_dp_d;
  logic [7:0]  shd_mask_d;

  logic        wrap;
  logic        commit;
  logic [7:0]  suppress;
  logic [3:0]  nibble;
  logic [7:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Handshake: load is a single-cycle strobe with no back-pressure; a newer load
  // simply replaces staging. loaded pulses for the one cycle whose edge moved
  // staging into the shadow copy that drives the display.
  assign wrap   = (sel_q == 3'd7) && (sel_in == 3'd0);
  assign commit = wrap && pending;

  always_comb begin
    sel_d       = sel_q;
    state_d     = state;
    blank_cnt_d = blank_cnt;
    if (sel_in != sel_q) begin
      sel_d = sel_in;
      if (BLANK_CYCLES == 0) begin
        state_d = ST_DRIVE;
      end else begin
        state_d     = ST_BLANK;
        blank_cnt_d = BLANK_RELOAD;
      end
    end else if (state == ST_BLANK) begin
      if (blank_cnt == 4'd0) begin
        state_d = ST_DRIVE;
      end else begin
        blank_cnt_d = blank_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    shd_digits_d = shd_digits;
    shd_dp_d     = shd_dp;
    shd_mask_d   = shd_mask;
    if (commit) begin
      shd_digits_d = stg_digits;
      shd_dp_d     = stg_dp;
      shd_mask_d   = stg_mask;
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    suppress   = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      zero_above  = zero_above && (shd_digits_d[4*i +: 4] == 4'h0);
      suppress[i] = LZ_SUPPRESS && (i != 0) && zero_above;
    end
  end

  assign nibble = shd_digits_d[{sel_d, 2'b00} +: 4];

  // Outputs are computed from next-state values so the registered pins line up
  // with the edge on which state changes.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if ((state_d == ST_DRIVE) && !shd_mask_d[sel_d]) begin
      an_d  = ~(8'd1 << sel_d);
      seg_d = suppress[sel_d] ? 7'h7F : seg_decode(nibble);
      dp_d  = ~shd_dp_d[sel_d];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_BLANK;
      blank_cnt <= BLANK_INIT;
      sel_q     <= 3'd0;
    end else begin
      state     <= state_d;
      blank_cnt <= blank_cnt_d;
      sel_q     <= sel_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stg_digits <= 32'h0;
      stg_dp     <= 8'h00;
      stg_mask   <= 8'hFF;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        stg_digits <= digits;
        stg_dp     <= dp_in;
        stg_mask   <= blank_mask;
        pending    <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      shd_digits <= 32'h0;
      shd_dp     <= 8'h00;
      shd_mask   <= 8'hFF;
    end else begin
      shd_digits <= shd_digits_d;
      shd_dp     <= shd_dp_d;
      shd_mask   <= shd_mask_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      an     <= 8'hFF;
      seg    <= 7'h7F;
      dp     <= 1'b1;
      loaded <= 1'b0;
    end else begin
      an     <= an_d;
      seg    <= seg_d;
      dp     <= dp_d;
      loaded <= commit;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: one instance with 4 blanking cycles and LZ on,
// a second with no blanking and LZ off, both driven from the same stimulus.
module tb_seg7_scan_driver;

  logic        aclk;
  logic        aresetn;
  logic [2:0]  select;
  logic [31:0] digits;
  logic [7:0]  dp_in;
  logic [7:0]  blank_mask;
  logic        load;

  logic        loaded;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        loaded0;
  logic [7:0]  an0;
  logic [6:0]  seg0;
  logic        dp0;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver #(.BLANK_CYCLES(4), .LZ_SUPPRESS(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn), .select(select), .digits(digits),
    .dp_in(dp_in), .blank_mask(blank_mask), .load(load), .loaded(loaded),
    .an(an), .seg(seg), .dp(dp)
  );

  seg7_scan_driver #(.BLANK_CYCLES(0), .LZ_SUPPRESS(1'b0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .select(select), .digits(digits),
    .dp_in(dp_in), .blank_mask(blank_mask), .load(load), .loaded(loaded0),
    .an(an0), .seg(seg0), .dp(dp0)
  );

  // clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    aresetn    = 1'b1;
    select     = 3'd0;
    digits     = 32'h0;
    dp_in      = 8'h00;
    blank_mask = 8'h00;
    load       = 1'b0;
  end

  // Drive select for n edges (load only on the first); sample 1ns after each edge.
  task automatic hold(input logic [2:0] s, input int n, input logic ld);
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      select = s;
      load   = ld && (k == 0);
      @(posedge aclk);
      #1;
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    #2 aresetn = 1'b0;
    for (int s = 0; s < 8; s++) begin
      hold(3'(s), 1, 1'b0);
      total++;
      if ({an, seg, dp, loaded} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold s=%0d got an=%h seg=%b dp=%b loaded=%b want an=ff seg=1111111 dp=1 loaded=0",
                 s, an, seg, dp, loaded);
      end
    end
    @(negedge aclk);
    aresetn = 1'b1;
    for (int s = 0; s < 8; s++) begin
      hold(3'(s), 6, 1'b0);
      total++;
      if ({an, an0, loaded} !== {8'hFF, 8'hFF, 1'b0}) begin
        bad++;
        $display("FAIL reset_dark s=%0d got an=%h an0=%h loaded=%b want an=ff an0=ff loaded=0",
                 s, an, an0, loaded);
      end
    end
  endtask

  task automatic test_commit;
    logic [6:0] exp_seg [8];
    logic       exp_dp  [8];
    exp_seg[0] = 7'b0001110; exp_dp[0] = 1'b1;
    exp_seg[1] = 7'b0001000; exp_dp[1] = 1'b0;
    exp_seg[2] = 7'b0100100; exp_dp[2] = 1'b1;
    exp_seg[3] = 7'b1111001; exp_dp[3] = 1'b1;
    for (int i = 4; i < 8; i++) begin
      exp_seg[i] = 7'h7F; exp_dp[i] = 1'b1;
    end
    digits = 32'h0000_12AF; dp_in = 8'h02; blank_mask = 8'h00;
    for (int s = 0; s < 8; s++) begin
      hold(3'(s), 6, (s == 3));
      total++;
      if ({an, loaded} !== {8'hFF, 1'b0}) begin
        bad++;
        $display("FAIL commit_pre s=%0d got an=%h loaded=%b want an=ff loaded=0", s, an, loaded);
      end
    end
    hold(3'd0, 1, 1'b0);
    total++;
    if (loaded !== 1'b1) begin
      bad++;
      $display("FAIL commit_loaded got %b want 1", loaded);
    end
    hold(3'd0, 5, 1'b0);
    total++;
    if (loaded !== 1'b0) begin
      bad++;
      $display("FAIL commit_loaded_once got %b want 0", loaded);
    end
    for (int s = 0; s < 8; s++) begin
      if (s != 0) hold(3'(s), 6, 1'b0);
      total++;
      if ({an, seg, dp} !== {~(8'd1 << s), exp_seg[s], exp_dp[s]}) begin
        bad++;
        $display("FAIL commit_digit s=%0d got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b",
                 s, an, seg, dp, ~(8'd1 << s), exp_seg[s], exp_dp[s]);
      end
      if (s == 4) begin
        total++;
        if (seg0 !== 7'b1000000) begin
          bad++;
          $display("FAIL nolz_digit4 got seg0=%b want 1000000", seg0);
        end
      end
    end
  endtask

  task automatic test_ghost;
    hold(3'd2, 6, 1'b0);
    hold(3'd3, 1, 1'b0);
    total++;
    if (an0 !== 8'hF7) begin
      bad++;
      $display("FAIL ghost_noblank got an0=%h want f7", an0);
    end
    for (int k = 0; k < 4; k++) begin
      if (k != 0) hold(3'd3, 1, 1'b0);
      total++;
      if (an !== 8'hFF) begin
        bad++;
        $display("FAIL ghost_blank edge=%0d got an=%h want ff", k, an);
      end
    end
    hold(3'd3, 1, 1'b0);
    total++;
    if (an !== 8'hF7) begin
      bad++;
      $display("FAIL ghost_drive got an=%h want f7", an);
    end
    hold(3'd4, 2, 1'b0);
    hold(3'd5, 4, 1'b0);
    total++;
    if (an !== 8'hFF) begin
      bad++;
      $display("FAIL ghost_restart got an=%h want ff", an);
    end
    hold(3'd5, 1, 1'b0);
    total++;
    if ({an, seg} !== {8'hDF, 7'h7F}) begin
      bad++;
      $display("FAIL ghost_restart_drive got an=%h seg=%b want an=df seg=1111111", an, seg);
    end
  endtask

  task automatic test_back_to_back;
    dp_in = 8'h00; blank_mask = 8'h00;
    digits = 32'h0000_0005;
    hold(3'd6, 6, 1'b1);
    hold(3'd7, 6, 1'b0);
    digits = 32'h0000_00C0;
    hold(3'd0, 1, 1'b1);
    total++;
    if (loaded !== 1'b1) begin
      bad++;
      $display("FAIL b2b_loaded_a got %b want 1", loaded);
    end
    hold(3'd0, 5, 1'b0);
    total++;
    if ({an, seg} !== {8'hFE, 7'b0010010}) begin
      bad++;
      $display("FAIL b2b_frame_a0 got an=%h seg=%b want an=fe seg=0010010", an, seg);
    end
    hold(3'd1, 6, 1'b0);
    total++;
    if ({an, seg} !== {8'hFD, 7'h7F}) begin
      bad++;
      $display("FAIL b2b_frame_a1 got an=%h seg=%b want an=fd seg=1111111", an, seg);
    end
    for (int s = 2; s < 8; s++) hold(3'(s), 6, 1'b0);
    hold(3'd0, 1, 1'b0);
    total++;
    if (loaded !== 1'b1) begin
      bad++;
      $display("FAIL b2b_loaded_b got %b want 1", loaded);
    end
    hold(3'd0, 5, 1'b0);
    total++;
    if (seg !== 7'b1000000) begin
      bad++;
      $display("FAIL b2b_frame_b0 got seg=%b want 1000000", seg);
    end
    hold(3'd1, 6, 1'b0);
    total++;
    if (seg !== 7'b1000110) begin
      bad++;
      $display("FAIL b2b_frame_b1 got seg=%b want 1000110", seg);
    end
    // pending is clear: a load on the wrap edge must wait a whole frame
    for (int s = 2; s < 8; s++) hold(3'(s), 6, 1'b0);
    digits = 32'h0000_0007;
    hold(3'd0, 1, 1'b1);
    total++;
    if (loaded !== 1'b0) begin
      bad++;
      $display("FAIL b2b_nopend_loaded got %b want 0", loaded);
    end
    hold(3'd0, 5, 1'b0);
    total++;
    if (seg !== 7'b1000000) begin
      bad++;
      $display("FAIL b2b_nopend_old got seg=%b want 1000000", seg);
    end
    for (int s = 1; s < 8; s++) hold(3'(s), 6, 1'b0);
    hold(3'd3, 1, 1'b0);
    total++;
    if (loaded !== 1'b0) begin
      bad++;
      $display("FAIL b2b_jump_not_wrap got loaded=%b want 0", loaded);
    end
    hold(3'd3, 5, 1'b0);
    for (int s = 4; s < 8; s++) hold(3'(s), 6, 1'b0);
    hold(3'd0, 1, 1'b0);
    total++;
    if (loaded !== 1'b1) begin
      bad++;
      $display("FAIL b2b_loaded_c got %b want 1", loaded);
    end
    hold(3'd0, 5, 1'b0);
    total++;
    if (seg !== 7'b1111000) begin
      bad++;
      $display("FAIL b2b_frame_c0 got seg=%b want 1111000", seg);
    end
  endtask

  task automatic test_reset_mid;
    hold(3'd5, 6, 1'b0);
    total++;
    if (an !== 8'hDF) begin
      bad++;
      $display("FAIL mid_drive got an=%h want df", an);
    end
    #2 aresetn = 1'b0;
    #1;
    total++;
    if ({an, seg, dp, loaded, an0} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 8'hFF}) begin
      bad++;
      $display("FAIL mid_async got an=%h seg=%b dp=%b loaded=%b an0=%h want an=ff seg=1111111 dp=1 loaded=0 an0=ff",
               an, seg, dp, loaded, an0);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    for (int s = 0; s < 8; s++) begin
      hold(3'(s), 6, 1'b0);
      total++;
      if ({an, an0} !== {8'hFF, 8'hFF}) begin
        bad++;
        $display("FAIL mid_dark s=%0d got an=%h an0=%h want ff ff", s, an, an0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_commit;
    test_ghost;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
